frv_leak_prng: RTL

- Multi-channel, width-parametrised successor to the core's leakage-barrier PRNG.
- Holds NUM_CH independent XNOR Fibonacci LFSRs. All channels step together on each leakage fence.
- Each channel can be reseeded at runtime through a valid/ready handshake.
- After a reseed, the reseeded channel runs a warm-up of WARMUP_CYCLES steps before outputs are declared valid again.
- Sits beside the leak/fence logic in the execute stage and feeds random masks to the register-clearing and masking datapaths.

---
 rtl/frv_leak_prng.sv | 115 +++++++++++
 1 files changed

// File: rtl/frv_leak_prng.sv
// frv_leak_prng: bank of XNOR Fibonacci LFSRs stepped on leakage fences, with per-channel reseed and warm-up.
// Optional macro FRV_LEAK_PRNG_LOCKUP_GUARD_EN keeps channels out of the all-ones lock-up state.
module frv_leak_prng #(
  parameter int                PRNG_W           = 32,
  parameter logic [PRNG_W-1:0] PRNG_TAPS        = 32'h80200003,
  parameter logic [PRNG_W-1:0] PRNG_RESET_VALUE = 32'hABCDEF37,
  parameter int                NUM_CH           = 2,
  parameter int                WARMUP_CYCLES    = 16,
  parameter int                CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic                     leak_fence,
  input  logic                     seed_valid,
  output logic                     seed_ready,
  input  logic [CH_W-1:0]          seed_ch,
  input  logic [PRNG_W-1:0]        seed_data,
  output logic [NUM_CH*PRNG_W-1:0] leak_prng,
  output logic                     leak_prng_valid,
  output logic                     leak_busy
);

  // state | meaning
  // RUN   | channels step on leak_fence, reseed accepted
  // WARM  | reseeded channel free-runs WARMUP_CYCLES steps, fences ignored
  typedef enum logic {RUN = 1'b0, WARM = 1'b1} state_t;

  localparam int                CNT_W    = $clog2(WARMUP_CYCLES + 1);
  localparam logic [PRNG_W-1:0] ALL_ONES = '1;
`ifdef FRV_LEAK_PRNG_LOCKUP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  function automatic logic [PRNG_W-1:0] step(input logic [PRNG_W-1:0] s);
    return {s[PRNG_W-2:0], ~(^(s & PRNG_TAPS))};
  endfunction

  function automatic logic [PRNG_W-1:0] rst_val(input int ch);
    logic [PRNG_W-1:0] r;
    int sh;
    r  = '0;
    sh = (8 * ch) % PRNG_W;
    for (int b = 0; b < PRNG_W; b++) r[(b + sh) % PRNG_W] = PRNG_RESET_VALUE[b];
    return r;
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CH_W-1:0]   sel, sel_nxt;
  logic [PRNG_W-1:0] ch_q   [NUM_CH];
  logic [PRNG_W-1:0] ch_nxt [NUM_CH];
  logic              seed_hit, seed_ok;

  assign seed_hit = seed_valid && seed_ready;
  assign seed_ok  = seed_hit && (int'(seed_ch) < NUM_CH);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= RUN;
      cnt   <= '0;
      sel   <= '0;
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= rst_val(i);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= ch_nxt[i];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_nxt[i] = ch_q[i];
      if (state == RUN) begin
        // a reseed wins over a same-cycle fence for the selected channel only
        if (seed_ok && int'(seed_ch) == i)
          ch_nxt[i] = (GUARD && seed_data == ALL_ONES) ? rst_val(i) : seed_data;
        else if (GUARD && ch_q[i] == ALL_ONES)
          ch_nxt[i] = rst_val(i);
        else if (leak_fence)
          ch_nxt[i] = step(ch_q[i]);
      end else if (int'(sel) == i) begin
        ch_nxt[i] = step(ch_q[i]);
      end
    end
    case (state)
      RUN: begin
        if (seed_ok) begin
          state_nxt = WARM;
          cnt_nxt   = CNT_W'(WARMUP_CYCLES);
          sel_nxt   = seed_ch;
        end
      end
      WARM: begin
        cnt_nxt = (cnt != '0) ? cnt - 1'b1 : '0;
        if (cnt <= CNT_W'(1)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign seed_ready      = (state == RUN);
  assign leak_prng_valid = (state == RUN);
  assign leak_busy       = (state == WARM);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign leak_prng[g*PRNG_W +: PRNG_W] = ch_q[g];
  end

endmodule
